// File: rtl/mips32_pipe_pkg.sv
// Shared types for the MIPS32 IF->ID boundary: the queued slot format and the NOP encoding.
package mips32_pipe_pkg;

    localparam int INSTR_W  = 32;
    localparam int PC_MAX_W = 32;

    localparam logic [INSTR_W-1:0] NOP_INSTR = 32'h0;

    typedef struct packed {
        logic [INSTR_W-1:0]  instr;
        logic [PC_MAX_W-1:0] pcadd4;
        logic [PC_MAX_W-1:0] rpc;
        logic                bds;
        logic                flushed;
    } ifid_entry_t;

    localparam ifid_entry_t IFID_ENTRY_RESET = '0;

    // A bubble keeps the PC bookkeeping of the previous slot so exception restart stays meaningful.
    function automatic ifid_entry_t make_bubble(input ifid_entry_t held);
        ifid_entry_t b;
        b         = held;
        b.instr   = NOP_INSTR;
        b.flushed = 1'b1;
        return b;
    endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Circular DEPTH-entry store of ifid_entry_t with occupancy count; clear empties it in one edge.
module fetch_fifo
    import mips32_pipe_pkg::*;
#(
    parameter  int DEPTH = 4,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             clear,
    input  logic             push,
    input  logic             pop,
    input  ifid_entry_t      wr_data,
    output ifid_entry_t      rd_data,
    output logic [CNT_W-1:0] count,
    output logic             full,
    output logic             empty
);

    ifid_entry_t      mem_q [DEPTH];
    ifid_entry_t      mem_d [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             do_push;
    logic             do_pop;

    assign full    = (count_q == CNT_W'(DEPTH));
    assign empty   = (count_q == '0);
    assign count   = count_q;
    assign rd_data = mem_q[rd_ptr_q];

    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (clear) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) begin
                mem_d[wr_ptr_q] = wr_data;
                wr_ptr_d        = PTR_W'(wr_ptr_q + 1'b1);
            end
            if (do_pop) begin
                rd_ptr_d = PTR_W'(rd_ptr_q + 1'b1);
            end
            // Push and pop together leave the count alone.
            case ({do_push, do_pop})
                2'b10:   count_d = CNT_W'(count_q + 1'b1);
                2'b01:   count_d = CNT_W'(count_q - 1'b1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            mem_q    <= '{default: IFID_ENTRY_RESET};
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: rtl/ifid_fetch_queue.sv
// IF->ID bridge: fetch queue plus ID pipeline register, with BDS restart-PC tracking and flush marking.
module ifid_fetch_queue
    import mips32_pipe_pkg::*;
#(
    parameter  int DEPTH  = 4,
    parameter  int PC_W   = 32,
    parameter  int BYPASS = 1,
    localparam int OCC_W  = $clog2(DEPTH + 1)
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             IF_Valid,
    output logic             IF_Ready,
    input  logic             IF_Flush,
    input  logic [31:0]      IF_Instruction,
    input  logic [PC_W-1:0]  IF_PCAdd4,
    input  logic [PC_W-1:0]  IF_PC,
    input  logic             IF_IsBDS,
    input  logic             Redirect,
    input  logic             ID_Stall,
    output logic             ID_Valid,
    output logic [31:0]      ID_Instruction,
    output logic [PC_W-1:0]  ID_PCAdd4,
    output logic [PC_W-1:0]  ID_RestartPC,
    output logic             ID_IsBDS,
    output logic             ID_IsFlushed,
    output logic [OCC_W-1:0] Occupancy
);

    ifid_entry_t      new_entry;
    ifid_entry_t      fifo_head;
    logic [OCC_W-1:0] fifo_count;
    logic             fifo_full;
    logic             fifo_empty;
    logic             fifo_push;
    logic             fifo_pop;
    logic             enq;
    logic             take_bypass;

    ifid_entry_t      id_q, id_d;
    logic             id_valid_q, id_valid_d;
    logic [PC_W-1:0]  last_rpc_q, last_rpc_d;

    // IF_Ready depends only on registered occupancy, never on ID_Stall.
    assign IF_Ready = ~fifo_full;
    assign enq      = IF_Valid & ~fifo_full & ~Redirect;

    always_comb begin
        new_entry.instr   = IF_Flush ? NOP_INSTR : IF_Instruction;
        new_entry.pcadd4  = PC_MAX_W'(IF_PCAdd4);
        new_entry.rpc     = IF_IsBDS ? PC_MAX_W'(last_rpc_q) : PC_MAX_W'(IF_PC);
        new_entry.bds     = IF_IsBDS;
        new_entry.flushed = IF_Flush;
    end

    always_comb begin
        last_rpc_d = last_rpc_q;
        if (enq && !IF_IsBDS) begin
            last_rpc_d = IF_PC;
        end
    end

    // ID register: Redirect beats stall; otherwise queue head, then bypass, then bubble.
    always_comb begin
        id_d        = id_q;
        id_valid_d  = id_valid_q;
        fifo_pop    = 1'b0;
        take_bypass = 1'b0;
        if (Redirect) begin
            id_d       = make_bubble(id_q);
            id_valid_d = 1'b0;
        end else if (!ID_Stall) begin
            if (!fifo_empty) begin
                id_d       = fifo_head;
                id_valid_d = 1'b1;
                fifo_pop   = 1'b1;
            end else if (enq && (BYPASS != 0)) begin
                id_d        = new_entry;
                id_valid_d  = 1'b1;
                take_bypass = 1'b1;
            end else begin
                id_d       = make_bubble(id_q);
                id_valid_d = 1'b0;
            end
        end
    end

    assign fifo_push = enq & ~take_bypass;

    fetch_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clock   (clock),
        .reset   (reset),
        .clear   (Redirect),
        .push    (fifo_push),
        .pop     (fifo_pop),
        .wr_data (new_entry),
        .rd_data (fifo_head),
        .count   (fifo_count),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            id_q       <= IFID_ENTRY_RESET;
            id_valid_q <= 1'b0;
            last_rpc_q <= '0;
        end else begin
            id_q       <= id_d;
            id_valid_q <= id_valid_d;
            last_rpc_q <= last_rpc_d;
        end
    end

    assign ID_Valid       = id_valid_q;
    assign ID_Instruction = id_q.instr;
    assign ID_PCAdd4      = id_q.pcadd4[PC_W-1:0];
    assign ID_RestartPC   = id_q.rpc[PC_W-1:0];
    assign ID_IsBDS       = id_q.bds;
    assign ID_IsFlushed   = id_q.flushed;
    assign Occupancy      = fifo_count;

endmodule

// File: tb/tb_ifid_fetch_queue.sv
// Directed bench for ifid_fetch_queue (DEPTH=4, BYPASS=1) with a short scoreboarded push/pop run.
module tb_ifid_fetch_queue;

    logic        clock;
    logic        reset;
    logic        IF_Valid;
    logic        IF_Ready;
    logic        IF_Flush;
    logic [31:0] IF_Instruction;
    logic [31:0] IF_PCAdd4;
    logic [31:0] IF_PC;
    logic        IF_IsBDS;
    logic        Redirect;
    logic        ID_Stall;
    logic        ID_Valid;
    logic [31:0] ID_Instruction;
    logic [31:0] ID_PCAdd4;
    logic [31:0] ID_RestartPC;
    logic        ID_IsBDS;
    logic        ID_IsFlushed;
    logic [2:0]  Occupancy;

    int errors = 0;
    int checks = 0;

    ifid_fetch_queue #(
        .DEPTH  (4),
        .PC_W   (32),
        .BYPASS (1)
    ) dut (
        .clock          (clock),
        .reset          (reset),
        .IF_Valid       (IF_Valid),
        .IF_Ready       (IF_Ready),
        .IF_Flush       (IF_Flush),
        .IF_Instruction (IF_Instruction),
        .IF_PCAdd4      (IF_PCAdd4),
        .IF_PC          (IF_PC),
        .IF_IsBDS       (IF_IsBDS),
        .Redirect       (Redirect),
        .ID_Stall       (ID_Stall),
        .ID_Valid       (ID_Valid),
        .ID_Instruction (ID_Instruction),
        .ID_PCAdd4      (ID_PCAdd4),
        .ID_RestartPC   (ID_RestartPC),
        .ID_IsBDS       (ID_IsBDS),
        .ID_IsFlushed   (ID_IsFlushed),
        .Occupancy      (Occupancy)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: observed=timeout required=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic applyStimulus(input logic v, input logic fl, input logic [31:0] instr,
                                 input logic [31:0] pc, input logic bds, input logic redir,
                                 input logic stall);
        IF_Valid       = v;
        IF_Flush       = fl;
        IF_Instruction = instr;
        IF_PC          = pc;
        IF_PCAdd4      = pc + 32'd4;
        IF_IsBDS       = bds;
        Redirect       = redir;
        ID_Stall       = stall;
    endtask

    task automatic advanceClock();
        @(posedge clock);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("[TB] FAIL %s: observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    task automatic checkId(input string tag, input logic v, input logic [31:0] instr,
                           input logic [31:0] pcadd4, input logic [31:0] rpc,
                           input logic bds, input logic fl);
        checkOutput({tag, " valid"},   32'(ID_Valid),     32'(v));
        checkOutput({tag, " instr"},   ID_Instruction,    instr);
        checkOutput({tag, " pcadd4"},  ID_PCAdd4,         pcadd4);
        checkOutput({tag, " rpc"},     ID_RestartPC,      rpc);
        checkOutput({tag, " bds"},     32'(ID_IsBDS),     32'(bds));
        checkOutput({tag, " flushed"}, 32'(ID_IsFlushed), 32'(fl));
    endtask

    initial begin
        int          q[$];
        logic [15:0] valid_pat;
        logic [15:0] stall_pat;
        logic        exp_valid;
        logic [31:0] exp_instr;
        logic [31:0] exp_rpc;
        logic        exp_ready;
        logic        enq;
        int          e;

        reset = 1'b1;
        applyStimulus(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
        advanceClock();
        advanceClock();
        checkId("reset", 1'b0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0);
        checkOutput("reset occ",   32'(Occupancy), 32'd0);
        checkOutput("reset ready", 32'(IF_Ready),  32'd1);
        reset = 1'b0;

        // Bypass into an empty queue: one-cycle latency.
        applyStimulus(1'b1, 1'b0, 32'h24020001, 32'h100, 1'b0, 1'b0, 1'b0);
        advanceClock();
        checkId("bypass", 1'b1, 32'h24020001, 32'h104, 32'h100, 1'b0, 1'b0);
        checkOutput("bypass occ", 32'(Occupancy), 32'd0);

        applyStimulus(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
        advanceClock();
        checkId("bubble", 1'b0, 32'h0, 32'h104, 32'h100, 1'b0, 1'b1);

        // Fill to DEPTH under stall, then drain in order.
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b1, 1'b0, 32'hA0 + i, 32'h300 + 4 * i, 1'b0, 1'b0, 1'b1);
            advanceClock();
        end
        checkOutput("fill occ",   32'(Occupancy), 32'd4);
        checkOutput("fill ready", 32'(IF_Ready),  32'd0);
        checkId("fill held", 1'b0, 32'h0, 32'h104, 32'h100, 1'b0, 1'b1);
        applyStimulus(1'b1, 1'b0, 32'hBAD, 32'h310, 1'b0, 1'b0, 1'b1);
        advanceClock();
        checkOutput("full push occ", 32'(Occupancy), 32'd4);
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
            advanceClock();
            checkId("drain", 1'b1, 32'hA0 + i, 32'h304 + 4 * i, 32'h300 + 4 * i, 1'b0, 1'b0);
            checkOutput("drain occ", 32'(Occupancy), 32'(3 - i));
        end

        // Branch then delay slot: the slot restarts at the branch.
        applyStimulus(1'b1, 1'b0, 32'h10000004, 32'h200, 1'b0, 1'b0, 1'b0);
        advanceClock();
        checkId("branch", 1'b1, 32'h10000004, 32'h204, 32'h200, 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b0, 32'h24030002, 32'h204, 1'b1, 1'b0, 1'b0);
        advanceClock();
        checkId("bds", 1'b1, 32'h24030002, 32'h208, 32'h200, 1'b1, 1'b0);

        applyStimulus(1'b1, 1'b1, 32'h8C430000, 32'h208, 1'b0, 1'b0, 1'b0);
        advanceClock();
        checkId("flush", 1'b1, 32'h0, 32'h20C, 32'h208, 1'b0, 1'b1);

        // Simultaneous push and pop.
        applyStimulus(1'b1, 1'b0, 32'h11, 32'h400, 1'b0, 1'b0, 1'b1);
        advanceClock();
        checkOutput("pp occ1", 32'(Occupancy), 32'd1);
        checkId("pp held", 1'b1, 32'h0, 32'h20C, 32'h208, 1'b0, 1'b1);
        applyStimulus(1'b1, 1'b0, 32'h22, 32'h404, 1'b0, 1'b0, 1'b0);
        advanceClock();
        checkId("pp first", 1'b1, 32'h11, 32'h404, 32'h400, 1'b0, 1'b0);
        checkOutput("pp occ2", 32'(Occupancy), 32'd1);
        applyStimulus(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
        advanceClock();
        checkId("pp second", 1'b1, 32'h22, 32'h408, 32'h404, 1'b0, 1'b0);
        checkOutput("pp occ3", 32'(Occupancy), 32'd0);

        // Redirect with 3 queued, ID stalled, and a push in the same cycle.
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b1, 1'b0, 32'h50 + i, 32'h500 + 4 * i, 1'b0, 1'b0, 1'b1);
            advanceClock();
        end
        checkOutput("redir pre occ", 32'(Occupancy), 32'd3);
        applyStimulus(1'b1, 1'b0, 32'h5F, 32'h50C, 1'b0, 1'b1, 1'b1);
        advanceClock();
        checkOutput("redir occ", 32'(Occupancy), 32'd0);
        checkId("redir", 1'b0, 32'h0, 32'h408, 32'h404, 1'b0, 1'b1);
        applyStimulus(1'b1, 1'b0, 32'h60, 32'h600, 1'b1, 1'b0, 1'b0);
        advanceClock();
        checkId("redir lastrpc", 1'b1, 32'h60, 32'h604, 32'h508, 1'b1, 1'b0);
        checkOutput("redir post occ", 32'(Occupancy), 32'd0);

        // Reset mid-fill.
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b1, 1'b0, 32'h70 + i, 32'h700 + 4 * i, 1'b0, 1'b0, 1'b1);
            advanceClock();
        end
        checkOutput("midfill occ", 32'(Occupancy), 32'd3);
        reset = 1'b1;
        applyStimulus(1'b1, 1'b0, 32'h7F, 32'h710, 1'b0, 1'b1, 1'b0);
        advanceClock();
        checkId("midrst", 1'b0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0);
        checkOutput("midrst occ",   32'(Occupancy), 32'd0);
        checkOutput("midrst ready", 32'(IF_Ready),  32'd1);
        reset = 1'b0;

        // Mixed push/pop run against a queue model.
        valid_pat = 16'b1101_1111_0110_1011;
        stall_pat = 16'b0011_1100_0001_1000;
        exp_valid = 1'b0;
        exp_instr = 32'h0;
        exp_rpc   = 32'h0;
        for (int i = 0; i < 16; i++) begin
            exp_ready = (q.size() < 4);
            checkOutput("sb ready", 32'(IF_Ready), 32'(exp_ready));
            enq = valid_pat[i] & exp_ready;
            applyStimulus(valid_pat[i], 1'b0, 32'h1000 + i, 32'h800 + 4 * i, 1'b0, 1'b0, stall_pat[i]);
            advanceClock();
            if (!stall_pat[i]) begin
                if (q.size() > 0) begin
                    e         = q.pop_front();
                    exp_valid = 1'b1;
                    exp_instr = 32'h1000 + e;
                    exp_rpc   = 32'h800 + 4 * e;
                end else if (enq) begin
                    exp_valid = 1'b1;
                    exp_instr = 32'h1000 + i;
                    exp_rpc   = 32'h800 + 4 * i;
                    enq       = 1'b0;
                end else begin
                    exp_valid = 1'b0;
                    exp_instr = 32'h0;
                end
            end
            if (enq) q.push_back(i);
            checkOutput("sb valid", 32'(ID_Valid),  32'(exp_valid));
            checkOutput("sb instr", ID_Instruction, exp_instr);
            checkOutput("sb rpc",   ID_RestartPC,   exp_rpc);
            checkOutput("sb occ",   32'(Occupancy), 32'(q.size()));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
